// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back commit queue.
package wb_pkg;

  localparam int WB_DEPTH_DEFAULT = 8;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_entry_t;

  localparam wb_entry_t WB_ENTRY_NULL = '0;

endpackage

// File: rtl/wb_lane_select.sv
// One write-back lane: picks the lane result and decides whether it needs a
// register-file write at all.
module wb_lane_select
  import wb_pkg::*;
(
  input  logic        memtoreg,
  input  logic        regwrite,
  input  logic [31:0] readdata,
  input  logic [31:0] aluout,
  input  logic [4:0]  writereg,
  output logic        valid,
  output wb_entry_t   entry
);

  always_comb begin
    entry.waddr = writereg;
    entry.wdata = memtoreg ? readdata : aluout;
    // Writes to $0 are architecturally discarded, so they never occupy a slot.
    valid       = regwrite && (writereg != REG_ZERO);
  end

endmodule

// File: rtl/wb_commit_queue.sv
// Dual-lane write-back commit queue draining into a single register-file write
// port. Optional pending-write bypass lookup enabled by WB_COMMIT_BYPASS_EN.
module wb_commit_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     memtoregw,
  input  logic                     memtoregw2,
  input  logic                     regwritew,
  input  logic                     regwritew2,
  input  logic [31:0]              readdataw,
  input  logic [31:0]              readdataw2,
  input  logic [31:0]              aluoutw,
  input  logic [31:0]              aluoutw2,
  input  logic [4:0]               writeregw,
  input  logic [4:0]               writeregw2,
  output logic                     stallw,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [31:0]              rf_wdata,
  input  logic [4:0]               byp_addr,
  output logic                     byp_hit,
  output logic [31:0]              byp_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic             lane1_valid, lane2_valid;
  wb_entry_t        lane1_entry, lane2_entry;
  logic             enq1, enq2, deq;

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  wb_entry_t        head_entry;

  wb_lane_select u_lane1 (
    .memtoreg (memtoregw),
    .regwrite (regwritew),
    .readdata (readdataw),
    .aluout   (aluoutw),
    .writereg (writeregw),
    .valid    (lane1_valid),
    .entry    (lane1_entry)
  );

  wb_lane_select u_lane2 (
    .memtoreg (memtoregw2),
    .regwrite (regwritew2),
    .readdata (readdataw2),
    .aluout   (aluoutw2),
    .writereg (writeregw2),
    .valid    (lane2_valid),
    .entry    (lane2_entry)
  );

  // Stall leaves headroom for a full dual-lane enqueue whenever it is low.
  assign stallw = (count_q > CNT_W'(DEPTH - 2));
  assign count  = count_q;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    mem_d   = mem_q;
    tail_d  = tail_q;
    head_d  = head_q;
    enq2    = !stallw && lane2_valid;
    // Lane 2 is younger; if both hit the same register lane 1 is dead.
    enq1    = !stallw && lane1_valid &&
              !(lane2_valid && (lane1_entry.waddr == lane2_entry.waddr));
    deq     = (count_q != '0);

    // NOTE: blocking updates here let lane 2 land at the tail already bumped by lane 1.
    if (enq1) begin
      mem_d[tail_d] = lane1_entry;
      tail_d        = tail_d + PTR_W'(1);
    end
    if (enq2) begin
      mem_d[tail_d] = lane2_entry;
      tail_d        = tail_d + PTR_W'(1);
    end
    if (deq) begin
      head_d = head_q + PTR_W'(1);
    end

    count_d = count_q + CNT_W'(enq1) + CNT_W'(enq2) - CNT_W'(deq);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      // NOTE: entry storage is cleared too, so stale data can never reach the write port.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= WB_ENTRY_NULL;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  // The register file always accepts, so the head is presented every non-empty cycle.
  always_comb begin
    rf_we      = (count_q != '0);
    head_entry = rf_we ? mem_q[head_q] : WB_ENTRY_NULL;
    rf_waddr   = head_entry.waddr;
    rf_wdata   = head_entry.wdata;
  end

`ifdef WB_COMMIT_BYPASS_EN
  logic [PTR_W-1:0] byp_idx;

  // Walk oldest to youngest so the last match is the youngest pending write;
  // the head being written this cycle is still part of the walk.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    byp_idx  = head_q;
    if (byp_addr != REG_ZERO) begin
      for (int i = 0; i < DEPTH; i++) begin
        byp_idx = head_q + PTR_W'(i);
        if ((CNT_W'(i) < count_q) && (mem_q[byp_idx].waddr == byp_addr)) begin
          byp_hit  = 1'b1;
          byp_data = mem_q[byp_idx].wdata;
        end
      end
    end
  end
`else
  logic byp_addr_unused;

  assign byp_addr_unused = ^byp_addr;
  assign byp_hit         = 1'b0;
  assign byp_data        = '0;
`endif

endmodule

// File: tb/tb_wb_commit_queue.sv
// Scoreboard bench for wb_commit_queue: expected writes are queued as lanes are
// accepted and compared as the DUT presents them on the register-file port.
module tb_wb_commit_queue;
  import wb_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef WB_COMMIT_BYPASS_EN
  localparam bit BYP_EN = 1'b1;
`else
  localparam bit BYP_EN = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             memtoregw, memtoregw2;
  logic             regwritew, regwritew2;
  logic [31:0]      readdataw, readdataw2, aluoutw, aluoutw2;
  logic [4:0]       writeregw, writeregw2;
  logic             stallw;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [31:0]      rf_wdata;
  logic [4:0]       byp_addr;
  logic             byp_hit;
  logic [31:0]      byp_data;
  logic [CNT_W-1:0] count;

  int        checks = 0;
  int        errors = 0;
  bit        mon_en = 1'b0;
  wb_entry_t sb[$];

  wb_commit_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .memtoregw  (memtoregw),
    .memtoregw2 (memtoregw2),
    .regwritew  (regwritew),
    .regwritew2 (regwritew2),
    .readdataw  (readdataw),
    .readdataw2 (readdataw2),
    .aluoutw    (aluoutw),
    .aluoutw2   (aluoutw2),
    .writeregw  (writeregw),
    .writeregw2 (writeregw2),
    .stallw     (stallw),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .byp_addr   (byp_addr),
    .byp_hit    (byp_hit),
    .byp_data   (byp_data),
    .count      (count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Youngest queued entry matching addr, from the scoreboard contents.
  task automatic byp_model(input logic [4:0] addr, output logic hit, output logic [31:0] data);
    hit  = 1'b0;
    data = '0;
    if (BYP_EN && addr != 5'd0) begin
      foreach (sb[i]) begin
        if (sb[i].waddr == addr) begin
          hit  = 1'b1;
          data = sb[i].wdata;
        end
      end
    end
  endtask

  // Output monitor: the scoreboard always mirrors what the DUT holds between edges.
  always @(negedge clk) begin
    logic        exp_hit;
    logic [31:0] exp_data;
    #1;
    if (mon_en && rst_n) begin
      checks++;
      if (count !== CNT_W'(sb.size())) begin
        errors++;
        $display("FAIL mon_count: got %0d expected %0d", count, sb.size());
      end
      checks++;
      if (stallw !== (sb.size() > DEPTH - 2)) begin
        errors++;
        $display("FAIL mon_stallw: got %0b expected %0b", stallw, sb.size() > DEPTH - 2);
      end
      checks++;
      if (sb.size() != 0) begin
        if (rf_we !== 1'b1 || rf_waddr !== sb[0].waddr || rf_wdata !== sb[0].wdata) begin
          errors++;
          $display("FAIL mon_write: got we=%0b r%0d=%h expected we=1 r%0d=%h",
                   rf_we, rf_waddr, rf_wdata, sb[0].waddr, sb[0].wdata);
        end
      end else begin
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
          errors++;
          $display("FAIL mon_idle: got we=%0b r%0d=%h expected we=0 r0=0",
                   rf_we, rf_waddr, rf_wdata);
        end
      end
      byp_model(byp_addr, exp_hit, exp_data);
      checks++;
      if (byp_hit !== exp_hit || byp_data !== exp_data) begin
        errors++;
        $display("FAIL mon_bypass: addr %0d got hit=%0b data=%h expected hit=%0b data=%h",
                 byp_addr, byp_hit, byp_data, exp_hit, exp_data);
      end
    end
  end

  // One clock: drive lanes, predict acceptance from the model occupancy, update
  // the scoreboard at the edge and return at the following falling edge.
  task automatic step(input logic rw1, input logic m1, input logic [4:0] w1,
                      input logic [31:0] rd1, input logic [31:0] al1,
                      input logic rw2, input logic m2, input logic [4:0] w2,
                      input logic [31:0] rd2, input logic [31:0] al2,
                      output bit acc);
    bit        q1, q2;
    wb_entry_t e1, e2;
    regwritew  = rw1; memtoregw  = m1; writeregw  = w1; readdataw  = rd1; aluoutw  = al1;
    regwritew2 = rw2; memtoregw2 = m2; writeregw2 = w2; readdataw2 = rd2; aluoutw2 = al2;
    acc = !(sb.size() > DEPTH - 2);
    q1  = rw1 && (w1 != 5'd0);
    q2  = rw2 && (w2 != 5'd0);
    if (q1 && q2 && w1 == w2) q1 = 1'b0;
    e1.waddr = w1; e1.wdata = m1 ? rd1 : al1;
    e2.waddr = w2; e2.wdata = m2 ? rd2 : al2;
    @(posedge clk);
    if (sb.size() != 0) void'(sb.pop_front());
    if (acc && q1) sb.push_back(e1);
    if (acc && q2) sb.push_back(e2);
    @(negedge clk);
  endtask

  task automatic idle();
    bit acc;
    step(0, 0, 5'd0, 32'd0, 32'd0, 0, 0, 5'd0, 32'd0, 32'd0, acc);
  endtask

  // Upstream holds the lanes until the queue accepts them.
  task automatic send(input logic [4:0] w1, input logic [31:0] d1,
                      input logic [4:0] w2, input logic [31:0] d2);
    bit acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      step(1, 0, w1, 32'hDEAD_0000, d1, 1, 1, w2, d2, 32'hDEAD_0001, acc);
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: got no accept within 20 cycles, expected accept");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {memtoregw, memtoregw2, regwritew, regwritew2} = '0;
    {readdataw, readdataw2, aluoutw, aluoutw2} = '0;
    {writeregw, writeregw2, byp_addr} = '0;
    #2;
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 ||
        stallw !== 1'b0 || byp_hit !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL reset_during: got we=%0b a=%0d d=%h stall=%0b hit=%0b cnt=%0d expected all 0",
               rf_we, rf_waddr, rf_wdata, stallw, byp_hit, count);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    #1;
    checks++;
    if (rf_we !== 1'b0 || count !== '0 || stallw !== 1'b0 || byp_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_after: got we=%0b cnt=%0d stall=%0b hit=%0b expected 0",
               rf_we, count, stallw, byp_hit);
    end
  endtask

  task automatic test_single_write();
    bit acc;
    step(1, 0, 5'd5, 32'hFFFF_FFFF, 32'h1234, 0, 0, 5'd0, 32'd0, 32'd0, acc);
    #1;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
      errors++;
      $display("FAIL single_write: got we=%0b r%0d=%h expected we=1 r5=00001234",
               rf_we, rf_waddr, rf_wdata);
    end
    idle();
    #1;
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL single_write_done: got we=%0b expected 0", rf_we);
    end
  endtask

  task automatic test_zero_reg();
    bit acc;
    step(1, 0, 5'd0, 32'd0, 32'hDEAD, 1, 1, 5'd0, 32'hBEEF, 32'd0, acc);
    #1;
    checks++;
    if (count !== '0 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL zero_reg: got cnt=%0d we=%0b expected cnt=0 we=0", count, rf_we);
    end
    idle();
  endtask

  task automatic test_same_dest();
    bit acc;
    step(1, 0, 5'd7, 32'd0, 32'hAAAA, 1, 1, 5'd7, 32'hBBBB, 32'h0, acc);
    #1;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hBBBB || count !== CNT_W'(1)) begin
      errors++;
      $display("FAIL same_dest: got we=%0b r%0d=%h cnt=%0d expected we=1 r7=0000bbbb cnt=1",
               rf_we, rf_waddr, rf_wdata, count);
    end
    idle();
    #1;
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL same_dest_once: got we=%0b expected 0", rf_we);
    end
  endtask

  task automatic test_fill();
    bit saw_stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send(5'(2 * i + 1), 32'h100 + 32'(i), 5'(2 * i + 2), 32'h200 + 32'(i));
      checks++;
      if (count > CNT_W'(DEPTH) || stallw !== (count >= CNT_W'(DEPTH - 1))) begin
        errors++;
        $display("FAIL fill_level: got cnt=%0d stall=%0b expected cnt<=8 stall=(cnt>=7)",
                 count, stallw);
      end
      if (stallw) saw_stall = 1'b1;
    end
    checks++;
    if (!saw_stall) begin
      errors++;
      $display("FAIL fill_stall: got stallw never 1 expected 1 near full");
    end
    for (int k = 0; k < 16 && sb.size() != 0; k++) idle();
    checks++;
    if (count !== '0 || sb.size() != 0) begin
      errors++;
      $display("FAIL fill_drain: got cnt=%0d pending=%0d expected 0 0", count, sb.size());
    end
  endtask

  task automatic test_bypass();
    bit acc;
    step(1, 0, 5'd9, 32'd0, 32'h99, 1, 0, 5'd3, 32'd0, 32'h10, acc);
    step(1, 0, 5'd3, 32'd0, 32'h20, 0, 0, 5'd0, 32'd0, 32'd0, acc);
    byp_addr = 5'd3;
    #1;
    checks++;
    if (byp_hit !== BYP_EN || byp_data !== (BYP_EN ? 32'h20 : 32'h0)) begin
      errors++;
      $display("FAIL bypass_young: got hit=%0b data=%h expected hit=%0b data=%h",
               byp_hit, byp_data, BYP_EN, BYP_EN ? 32'h20 : 32'h0);
    end
    #1 byp_addr = 5'd0;
    #1;
    checks++;
    if (byp_hit !== 1'b0 || byp_data !== 32'd0) begin
      errors++;
      $display("FAIL bypass_r0: got hit=%0b data=%h expected 0 0", byp_hit, byp_data);
    end
    #1 byp_addr = 5'd9;
    #1;
    checks++;
    if (byp_hit !== 1'b0 || byp_data !== 32'd0) begin
      errors++;
      $display("FAIL bypass_nomatch: got hit=%0b data=%h expected 0 0", byp_hit, byp_data);
    end
    byp_addr = 5'd3;
    idle();
    #1;
    checks++;
    if (byp_hit !== BYP_EN || byp_data !== (BYP_EN ? 32'h20 : 32'h0)) begin
      errors++;
      $display("FAIL bypass_head: got hit=%0b data=%h expected hit=%0b data=%h",
               byp_hit, byp_data, BYP_EN, BYP_EN ? 32'h20 : 32'h0);
    end
    idle();
    byp_addr = 5'd0;
  endtask

  task automatic test_reset_mid_op();
    for (int i = 0; i < 4; i++) begin
      send(5'(10 + 2 * i), 32'h500 + 32'(i), 5'(11 + 2 * i), 32'h600 + 32'(i));
    end
    checks++;
    if (count !== CNT_W'(5)) begin
      errors++;
      $display("FAIL midrst_pre: got cnt=%0d expected 5", count);
    end
    {regwritew, regwritew2} = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (count !== '0 || rf_we !== 1'b0 || rf_waddr !== 5'd0 || stallw !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: got cnt=%0d we=%0b a=%0d stall=%0b expected all 0",
               count, rf_we, rf_waddr, stallw);
    end
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idle();
      checks++;
      if (rf_we !== 1'b0) begin
        errors++;
        $display("FAIL midrst_nowrite: got we=%0b in cycle %0d expected 0", rf_we, k);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_zero_reg();
    test_same_dest();
    test_fill();
    test_bypass();
    test_reset_mid_op();
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_commit_queue.md
WB_COMMIT_QUEUE -- requirements
Module: wb_commit_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of queue entries (power of two, >=4).
REQ-002 SHALL have port clk, input, 1 bit, meaning the single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1 bit, meaning the asynchronous active-low reset.
REQ-004 SHALL have ports memtoregw and memtoregw2, input, 1 bit each, meaning the lane 1 and lane 2 result select (1 = readdata, 0 = aluout).
REQ-005 SHALL have ports regwritew and regwritew2, input, 1 bit each, meaning the lane 1 and lane 2 write enables.
REQ-006 SHALL have ports readdataw, readdataw2, aluoutw and aluoutw2, input, 32 bits each, meaning the lane load data and ALU results.
REQ-007 SHALL have ports writeregw and writeregw2, input, 5 bits each, meaning the lane destination registers.
REQ-008 SHALL have port stallw, output, 1 bit, meaning backpressure to the MEM/WB register (its stall input).
REQ-009 SHALL have ports rf_we (output, 1 bit), rf_waddr (output, 5 bits) and rf_wdata (output, 32 bits), meaning the single register-file write port.
REQ-010 SHALL have ports byp_addr (input, 5 bits), byp_hit (output, 1 bit) and byp_data (output, 32 bits), meaning the pending-write bypass lookup.
REQ-011 SHALL have port count, output, $clog2(DEPTH)+1 bits, meaning the current queue occupancy.

Function
REQ-012 SHALL form each lane result as memtoreg ? readdata : aluout.
REQ-013 SHALL accept the inputs on a rising edge only when stallw=0; when stallw=1 the inputs SHALL be ignored because upstream holds them.
REQ-014 SHALL enqueue a lane only if its regwrite=1 and its writereg!=0.
REQ-015 SHALL enqueue lane 1 before lane 2 when both qualify, so program order is preserved.
REQ-016 SHALL drop lane 1 and enqueue only lane 2 when both lanes qualify with the same writereg.
REQ-017 SHALL make the head entry visible combinationally: rf_we = (count!=0), rf_waddr/rf_wdata = head entry, and 0 when empty.
REQ-018 SHALL dequeue the head on every edge where count!=0, because the register file always accepts.
REQ-019 SHALL apply 0, 1 or 2 enqueues and 0 or 1 dequeue on the same edge, with count updated by the net change.
REQ-020 SHALL give an entry enqueued into an empty queue at edge N rf_we=1 during the cycle after edge N (1-cycle latency).
REQ-021 SHALL drive stallw combinationally from the registered count as (count > DEPTH-2), guaranteeing room for 2 entries whenever stallw=0.
REQ-022 SHALL wrap the head and tail pointers modulo DEPTH, and count SHALL never exceed DEPTH.
REQ-023 SHALL set byp_hit=1 with byp_data equal to the youngest queued entry whose waddr equals byp_addr; byp_addr=0 or no match SHALL give hit=0 and data=0.
REQ-024 SHALL include in the bypass lookup the head entry being written this cycle, and SHALL NOT include the lane inputs.

Reset
REQ-025 SHALL on rst_n=0, asynchronously clear head, tail and count to 0, and clear all entry storage to 0.
REQ-026 SHALL during and immediately after reset drive rf_we=0, rf_waddr=0, rf_wdata=0, stallw=0 and byp_hit=0.
REQ-027 SHALL on reset mid-operation discard all pending entries, with no register-file write issued for them.

Configuration
REQ-028 SHALL include the bypass lookup logic of REQ-023/024 only when macro WB_COMMIT_BYPASS_EN is defined.
REQ-029 SHALL keep the byp_* ports when WB_COMMIT_BYPASS_EN is undefined, with byp_hit tied 0 and byp_data tied 0.

Structure
REQ-030 SHALL place the entry type {waddr[4:0], wdata[31:0]}, the DEPTH default and the register-zero constant in shared package wb_pkg.
REQ-031 SHALL implement the per-lane result mux plus qualify logic in one sub-module wb_lane_select, instanced twice.

Verification
REQ-032 SHALL cover a single write: lane1 regwrite=1, writereg=5, aluout=0x1234, memtoreg=0 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; following cycle rf_we=0.
REQ-033 SHALL cover same destination: both lanes write reg 7, lane1=0xAAAA, lane2 load 0xBBBB -> exactly one write, reg 7 = 0xBBBB.
REQ-034 SHALL cover fill: both lanes write distinct registers every accepted cycle with DEPTH=8 -> stallw=1 once count>=7, count never >8, all writes drain in order.
REQ-035 SHALL cover $0: writereg=0 with regwrite=1 -> no enqueue, count unchanged, rf_we stays 0.
REQ-036 SHALL cover bypass: queue holds reg 3=0x10 (older) and reg 3=0x20 (younger), byp_addr=3 -> byp_hit=1, byp_data=0x20; with the macro undefined -> byp_hit=0.
REQ-037 SHALL cover reset mid-operation: assert rst_n=0 with count=5 -> count=0, rf_we=0 immediately and asynchronously, and no further writes issue.
